rf_access_unit: RTL

Initiator-side companion to the 2R1W register file. It accepts operand-read requests from decode and writeback requests from two producers, an ALU (wb0) and a load unit (wb1). Writebacks are serialised through a small FIFO onto the file's single write port. Read operands are returned with forwarding from in-flight writes, so consumers always see the newest architectural value.

---
 rtl/rf_access_pkg.sv | 43 ++++
 rtl/rf_access_unit_if.sv | 49 ++++
 rtl/rf_wb_fifo.sv | 67 ++++++
 rtl/rf_access_unit.sv | 120 ++++++++++++
 4 files changed

// File: rtl/rf_access_pkg.sv
// Shared widths, writeback entry type and the newest-first forwarding search
// used by the register-file access unit.
package rf_access_pkg;

    localparam int unsigned DATA_WIDTH    = 32;
    localparam int unsigned REG_FILE_SIZE = 32;
    localparam int unsigned WB_FIFO_DEPTH = 4;
    localparam int unsigned RF_ADDR_WIDTH = $clog2(REG_FILE_SIZE);
    localparam int unsigned AW            = RF_ADDR_WIDTH;
    localparam int unsigned FIFO_PTR_W    = $clog2(WB_FIFO_DEPTH);
    localparam int unsigned FIFO_CNT_W    = FIFO_PTR_W + 1;

    typedef struct packed {
        logic [AW-1:0]         rd;
        logic [DATA_WIDTH-1:0] data;
    } wb_entry_t;

    typedef struct packed {
        logic                  hit;
        logic [DATA_WIDTH-1:0] data;
    } fwd_t;

    // Walks oldest to newest so the youngest matching entry wins.
    function automatic fwd_t fwd_select(
        input wb_entry_t                ents [WB_FIFO_DEPTH],
        input logic [WB_FIFO_DEPTH-1:0] vld,
        input logic [FIFO_PTR_W-1:0]    wr_ptr,
        input logic [AW-1:0]            rs
    );
        fwd_t                  res;
        logic [FIFO_PTR_W-1:0] idx;
        res = '0;
        for (int k = WB_FIFO_DEPTH; k >= 1; k--) begin
            idx = wr_ptr - FIFO_PTR_W'(k);
            if (vld[idx] && (ents[idx].rd == rs)) begin
                res.hit  = 1'b1;
                res.data = ents[idx].data;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rf_access_unit_if.sv
// Bundle of the decode read port, the two writeback producers and the
// register-file port pair seen by the access unit.
interface rf_access_unit_if;
    import rf_access_pkg::*;

    logic                  rd_valid;
    logic                  rd_ready;
    logic [AW-1:0]         rd_rs1;
    logic [AW-1:0]         rd_rs2;
    logic                  rd_out_valid;
    logic [DATA_WIDTH-1:0] rd_op1;
    logic [DATA_WIDTH-1:0] rd_op2;

    logic                  wb0_valid;
    logic                  wb0_ready;
    logic [AW-1:0]         wb0_rd;
    logic [DATA_WIDTH-1:0] wb0_data;
    logic                  wb1_valid;
    logic                  wb1_ready;
    logic [AW-1:0]         wb1_rd;
    logic [DATA_WIDTH-1:0] wb1_data;

    logic [AW-1:0]         rf_raddr1;
    logic [AW-1:0]         rf_raddr2;
    logic [DATA_WIDTH-1:0] rf_rdata1;
    logic [DATA_WIDTH-1:0] rf_rdata2;
    logic                  rf_wen;
    logic [AW-1:0]         rf_waddr;
    logic [DATA_WIDTH-1:0] rf_wdata;

    modport slave (
        input  rd_valid, rd_rs1, rd_rs2,
        input  wb0_valid, wb0_rd, wb0_data, wb1_valid, wb1_rd, wb1_data,
        input  rf_rdata1, rf_rdata2,
        output rd_ready, rd_out_valid, rd_op1, rd_op2,
        output wb0_ready, wb1_ready,
        output rf_raddr1, rf_raddr2, rf_wen, rf_waddr, rf_wdata
    );

    modport master (
        output rd_valid, rd_rs1, rd_rs2,
        output wb0_valid, wb0_rd, wb0_data, wb1_valid, wb1_rd, wb1_data,
        output rf_rdata1, rf_rdata2,
        input  rd_ready, rd_out_valid, rd_op1, rd_op2,
        input  wb0_ready, wb1_ready,
        input  rf_raddr1, rf_raddr2, rf_wen, rf_waddr, rf_wdata
    );

endinterface

// File: rtl/rf_wb_fifo.sv
// Writeback buffer: small synchronous FIFO that also exposes every slot and
// a live mask so the read path can forward from in-flight writes.
module rf_wb_fifo
    import rf_access_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  wb_entry_t                i_push_entry,
    input  logic                     i_pop,
    output wb_entry_t                o_head_c,
    output wb_entry_t                o_entries [WB_FIFO_DEPTH],
    output logic [WB_FIFO_DEPTH-1:0] o_valid_mask_c,
    output logic [FIFO_PTR_W-1:0]    o_wr_ptr,
    output logic                     o_full_c,
    output logic                     o_empty_c
);

    logic [FIFO_PTR_W-1:0] r_wr_ptr;
    logic [FIFO_PTR_W-1:0] r_rd_ptr;
    logic [FIFO_CNT_W-1:0] r_count;
    wb_entry_t             r_mem [WB_FIFO_DEPTH];
    logic                  w_push;
    logic                  w_pop;

    assign o_full_c  = (r_count == FIFO_CNT_W'(WB_FIFO_DEPTH));
    assign o_empty_c = (r_count == '0);
    assign w_push    = i_push && !o_full_c;
    assign w_pop     = i_pop && !o_empty_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < WB_FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_push_entry;
                r_wr_ptr        <= r_wr_ptr + FIFO_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + FIFO_PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + FIFO_CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - FIFO_CNT_W'(1);
            end
        end
    end

    // A slot is live when its distance from the read pointer is below the occupancy.
    always_comb begin
        o_valid_mask_c = '0;
        for (int i = 0; i < WB_FIFO_DEPTH; i++) begin
            o_valid_mask_c[i] = (FIFO_CNT_W'(FIFO_PTR_W'(i) - r_rd_ptr) < r_count);
        end
    end

    assign o_head_c  = r_mem[r_rd_ptr];
    assign o_entries = r_mem;
    assign o_wr_ptr  = r_wr_ptr;

endmodule

// File: rtl/rf_access_unit.sv
// Register-file access unit: arbitrates two writeback producers into a
// buffered single write port and serves two-stage forwarded operand reads.
module rf_access_unit
    import rf_access_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    rf_access_unit_if.slave  io_bus
);

    logic                     r_active;
    logic                     r_s1_valid;
    logic                     r_out_valid;
    logic [AW-1:0]            r_raddr1;
    logic [AW-1:0]            r_raddr2;
    logic [DATA_WIDTH-1:0]    r_op1;
    logic [DATA_WIDTH-1:0]    r_op2;
    logic                     r_wen;
    wb_entry_t                r_commit;

    logic                     w_full;
    logic                     w_empty;
    wb_entry_t                w_head;
    wb_entry_t                w_entries [WB_FIFO_DEPTH];
    logic [WB_FIFO_DEPTH-1:0] w_vld_mask;
    logic [FIFO_PTR_W-1:0]    w_wr_ptr;
    logic                     w_wb0_hs;
    logic                     w_wb1_hs;
    logic                     w_push;
    wb_entry_t                w_push_entry;
    fwd_t                     w_fwd1;
    fwd_t                     w_fwd2;
    logic [DATA_WIDTH-1:0]    w_op1_nxt;
    logic [DATA_WIDTH-1:0]    w_op2_nxt;

    // Buffered entries are younger than the write leaving the commit register, so they win.
    function automatic logic [DATA_WIDTH-1:0] pick_operand(
        input logic [AW-1:0]         rs,
        input logic [DATA_WIDTH-1:0] rdata,
        input fwd_t                  fwd,
        input logic                  wen,
        input wb_entry_t             commit
    );
        if (rs == '0)                     return '0;
        else if (fwd.hit)                 return fwd.data;
        else if (wen && commit.rd == rs)  return commit.data;
        else                              return rdata;
    endfunction

    assign io_bus.wb0_ready = r_active && !w_full;
    assign io_bus.wb1_ready = r_active && !w_full && !io_bus.wb0_valid;
    assign w_wb0_hs         = io_bus.wb0_valid && io_bus.wb0_ready;
    assign w_wb1_hs         = io_bus.wb1_valid && io_bus.wb1_ready;
    assign w_push_entry     = w_wb0_hs ? wb_entry_t'{io_bus.wb0_rd, io_bus.wb0_data}
                                       : wb_entry_t'{io_bus.wb1_rd, io_bus.wb1_data};
    assign w_push           = (w_wb0_hs || w_wb1_hs) && (w_push_entry.rd != '0);

    rf_wb_fifo u_wb_fifo (
        .clk            (clk),
        .rst            (rst),
        .i_push         (w_push),
        .i_push_entry   (w_push_entry),
        .i_pop          (!w_empty),
        .o_head_c       (w_head),
        .o_entries      (w_entries),
        .o_valid_mask_c (w_vld_mask),
        .o_wr_ptr       (w_wr_ptr),
        .o_full_c       (w_full),
        .o_empty_c      (w_empty)
    );

    always_comb begin
        w_fwd1    = fwd_select(w_entries, w_vld_mask, w_wr_ptr, r_raddr1);
        w_fwd2    = fwd_select(w_entries, w_vld_mask, w_wr_ptr, r_raddr2);
        w_op1_nxt = pick_operand(r_raddr1, io_bus.rf_rdata1, w_fwd1, r_wen, r_commit);
        w_op2_nxt = pick_operand(r_raddr2, io_bus.rf_rdata2, w_fwd2, r_wen, r_commit);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_active    <= 1'b0;
            r_s1_valid  <= 1'b0;
            r_out_valid <= 1'b0;
            r_raddr1    <= '0;
            r_raddr2    <= '0;
            r_op1       <= '0;
            r_op2       <= '0;
            r_wen       <= 1'b0;
            r_commit    <= '0;
        end else begin
            r_active    <= 1'b1;
            r_s1_valid  <= io_bus.rd_valid && r_active;
            r_out_valid <= r_s1_valid;
            if (io_bus.rd_valid && r_active) begin
                r_raddr1 <= io_bus.rd_rs1;
                r_raddr2 <= io_bus.rd_rs2;
            end
            if (r_s1_valid) begin
                r_op1 <= w_op1_nxt;
                r_op2 <= w_op2_nxt;
            end
            // Head moves into the commit register; address/data hold while idle.
            r_wen <= !w_empty;
            if (!w_empty) begin
                r_commit <= w_head;
            end
        end
    end

    assign io_bus.rd_ready     = r_active;
    assign io_bus.rd_out_valid = r_out_valid;
    assign io_bus.rd_op1       = r_op1;
    assign io_bus.rd_op2       = r_op2;
    assign io_bus.rf_raddr1    = r_raddr1;
    assign io_bus.rf_raddr2    = r_raddr2;
    assign io_bus.rf_wen       = r_wen;
    assign io_bus.rf_waddr     = r_commit.rd;
    assign io_bus.rf_wdata     = r_commit.data;

endmodule
